branch_predictor_btb: RTL and testbench
=======================================

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 Parameter INDEX_W, default 5, log2 of the entry count (2**INDEX_W entries, direct-mapped).
REQ-002 Parameter TAG_W, default 8, stored tag width.
REQ-003 Parameter CNT_W, default 2, saturating-counter width; legal range 1..4.
REQ-004 Parameter PC_W, default 64, PC and target width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 arst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  global enable; when 0, no lookup is accepted and no update or flush is applied.
REQ-008 lookup_valid  in  1  lookup request strobe.
REQ-009 lookup_pc  in  PC_W  PC to predict.
REQ-010 pred_valid  out  1  prediction result valid.
REQ-011 pred_hit  out  1  lookup matched a valid entry.
REQ-012 pred_taken  out  1  predicted taken.
REQ-013 pred_target  out  PC_W  predicted target; 0 when pred_hit=0.
REQ-014 upd_valid  in  1  resolved-branch update strobe.
REQ-015 upd_pc, upd_target  in  PC_W  branch PC and resolved target.
REQ-016 upd_taken  in  1  resolved direction.
REQ-017 flush  in  1  invalidate all entries.

Function
REQ-018 Index = pc[INDEX_W+1:2]; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]; pc[1:0] is ignored.
REQ-019 Each entry holds valid, tag, target[PC_W], cnt[CNT_W].
REQ-020 Lookup latency is 1 cycle: lookup_valid&en at edge N gives pred_valid=1 during cycle N+1; otherwise pred_valid=0.
REQ-021 pred_hit = valid && tag match; pred_taken = pred_hit && cnt[CNT_W-1]; pred_target = entry target when pred_hit, else 0.
REQ-022 Update on hit (upd_valid&en, valid, tag match): taken gives cnt+1, saturating at 2**CNT_W-1, and writes the target; not-taken gives cnt-1, saturating at 0, and leaves the target unchanged.
REQ-023 Update on miss with upd_taken=1 allocates/replaces the entry: valid=1, new tag, target=upd_target, cnt=2**(CNT_W-1) (weakly taken).
REQ-024 Update on miss with upd_taken=0 changes nothing.
REQ-025 flush&en clears every valid bit at the next edge; cnt, tag and target are unchanged; an update in the same cycle is dropped.
REQ-026 A lookup and an update/flush in the same cycle to the same index resolve as defined in REQ-031/REQ-032.
REQ-027 en=0 holds all state; pred_valid=0 in the following cycle.

Reset
REQ-028 arst asserted immediately clears all valid bits and all cnt fields to 0, and sets pred_valid, pred_hit, pred_taken and pred_target to 0.
REQ-029 Tag and target storage are not reset.
REQ-030 A lookup in flight when arst is asserted is discarded; pred_valid=0 for the first cycle after release.

Configuration
REQ-031 With BTB_FWD_EN defined, a same-cycle, same-index update or flush is forwarded: the prediction reflects post-update state, and flush forces pred_hit=0.
REQ-032 Without BTB_FWD_EN, the prediction reflects pre-edge state; the update becomes visible to lookups from the next cycle.

Structure
REQ-033 Package btb_pkg SHALL hold: the entry struct typedef, index/tag extraction functions, and the counter init, max and zero constant functions of CNT_W.
REQ-034 Sub-module btb_sat_counter (CNT_W parameter; inputs cnt, inc, dec; output next cnt, saturating) SHALL implement REQ-022.
REQ-035 Target implementation size is 120-400 lines of RTL.

Verification
REQ-036 Reset, then lookup pc=0x1000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
REQ-037 Update pc=0x1000, taken, target=0x2000, then lookup 0x1000 -> pred_hit=1, pred_taken=1, pred_target=0x2000, cnt=2.
REQ-038 Three taken updates, then four not-taken updates to 0x1000 (CNT_W=2) -> cnt 3,3,3 then 2,1,0,0; pred_taken 1 until cnt<2, then 0.
REQ-039 Alias case: entry at 0x1000; taken update pc=0x1000+(1<<(INDEX_W+2)) -> replaced, and lookup 0x1000 gives pred_hit=0.
REQ-040 flush together with an update and a lookup of 0x1000 -> update dropped; pred_hit=0 with BTB_FWD_EN, old entry hit without it; all later lookups miss.
REQ-041 arst asserted mid-lookup -> pred_valid falls to 0 asynchronously; all lookups miss after release.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared entry layout, PC field extraction and counter constants for the BTB.
package btb_pkg;
  localparam int BTB_TAG_W = 8;
  localparam int BTB_PC_W = 64;
  localparam int BTB_CNT_W = 2;
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_PC_W-1:0]  target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;
  function automatic int unsigned btb_index(input logic [63:0] pc, input int index_w);
    return 32'((pc >> 2) & ((64'd1 << index_w) - 64'd1));
  endfunction
  function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int index_w, input int tag_w);
    return (pc >> (index_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction
  function automatic logic [3:0] cnt_init(input int cnt_w);
    return 4'(1 << (cnt_w - 1));
  endfunction
  function automatic logic [3:0] cnt_max(input int cnt_w);
    return 4'((1 << cnt_w) - 1);
  endfunction
  function automatic logic [3:0] cnt_zero(input int cnt_w);
    return 4'(0 * cnt_w);
  endfunction
endpackage

// File: rtl/btb_sat_counter.sv
// btb_sat_counter: next value of a CNT_W-bit up/down counter saturating at 0 and its maximum.
module btb_sat_counter import btb_pkg::*; #(
  parameter int CNT_W = 2
)(
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] nxt
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(cnt_zero(CNT_W));
  always_comb nxt = (inc && cnt != MAX) ? cnt + 1'b1 : (dec && cnt != ZERO) ? cnt - 1'b1 : cnt;
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with saturating direction counters, 1-cycle lookup.
// Define BTB_FWD_EN to forward same-cycle updates/flushes into the lookup result.
module branch_predictor_btb import btb_pkg::*; #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 64
)(
  input  logic            clk,
  input  logic            arst,
  input  logic            en,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush
);
  localparam int N = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  logic [N-1:0]       valid_q;
  logic [CNT_W-1:0]   cnt_q [N];
  logic [TAG_W-1:0]   tag_q [N];
  logic [PC_W-1:0]    tgt_q [N];
  logic [INDEX_W-1:0] idx_l, idx_u;
  logic [TAG_W-1:0]   tag_l, tag_u;
  logic               upd_hit, do_flush, do_upd, wr_alloc, wr_hit, wr_tgt, look;
  logic [CNT_W-1:0]   cnt_step, cnt_new;
  logic               l_valid, l_hit;
  logic [TAG_W-1:0]   l_tag;
  logic [CNT_W-1:0]   l_cnt;
  logic [PC_W-1:0]    l_tgt;
  assign idx_l = INDEX_W'(btb_index(64'(lookup_pc), INDEX_W));
  assign idx_u = INDEX_W'(btb_index(64'(upd_pc), INDEX_W));
  assign tag_l = TAG_W'(btb_tag(64'(lookup_pc), INDEX_W, TAG_W));
  assign tag_u = TAG_W'(btb_tag(64'(upd_pc), INDEX_W, TAG_W));
  btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .cnt(cnt_q[idx_u]),
    .inc(upd_taken),
    .dec(!upd_taken),
    .nxt(cnt_step)
  );
  // flush wins over an update issued in the same cycle
  always_comb begin
    do_flush = en && flush;
    do_upd   = en && upd_valid && !flush;
    upd_hit  = valid_q[idx_u] && tag_q[idx_u] == tag_u;
    wr_hit   = do_upd && upd_hit;
    wr_alloc = do_upd && !upd_hit && upd_taken;
    wr_tgt   = wr_alloc || (wr_hit && upd_taken);
    cnt_new  = wr_alloc ? CNT_INIT : cnt_step;
    look     = en && lookup_valid;
  end
`ifdef BTB_FWD_EN
  logic same;
  always_comb begin
    same    = idx_l == idx_u;
    l_valid = !do_flush && ((same && wr_alloc) || valid_q[idx_l]);
    l_tag   = (same && wr_alloc) ? tag_u : tag_q[idx_l];
    l_cnt   = (same && (wr_alloc || wr_hit)) ? cnt_new : cnt_q[idx_l];
    l_tgt   = (same && wr_tgt) ? upd_target : tgt_q[idx_l];
    l_hit   = l_valid && l_tag == tag_l;
  end
`else
  always_comb begin
    l_valid = valid_q[idx_l];
    l_tag   = tag_q[idx_l];
    l_cnt   = cnt_q[idx_l];
    l_tgt   = tgt_q[idx_l];
    l_hit   = l_valid && l_tag == tag_l;
  end
`endif
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (do_flush) begin
      valid_q <= '0;
    end else if (wr_alloc || wr_hit) begin
      valid_q[idx_u] <= 1'b1;
      cnt_q[idx_u]   <= cnt_new;
    end
  always_ff @(posedge clk) begin
    if (wr_alloc) tag_q[idx_u] <= tag_u;
    if (wr_tgt) tgt_q[idx_u] <= upd_target;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= look;
      pred_hit    <= look && l_hit;
      pred_taken  <= look && l_hit && l_cnt[CNT_W-1];
      pred_target <= (look && l_hit) ? l_tgt : '0;
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed and random checks of the BTB against an array model.
module tb_branch_predictor_btb;
  import btb_pkg::*;
  logic clk = 0, arst = 1, en = 0, lookup_valid = 0, upd_valid = 0, upd_taken = 0, flush = 0;
  logic [63:0] lookup_pc = 0, upd_pc = 0, upd_target = 0;
  logic pred_valid, pred_hit, pred_taken;
  logic [63:0] pred_target;
  int tests = 0, errors = 0;
  btb_entry_t m [32];

  branch_predictor_btb dut (
    .clk(clk), .arst(arst), .en(en),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m[i].valid = 0;
      m[i].cnt = 0;
    end
  endfunction

  function automatic void model_look(input logic [63:0] pc, output bit h, output bit tk, output logic [63:0] tg);
    int i = int'((pc / 4) % 32);
    int t = int'((pc / 128) % 256);
    h  = m[i].valid && int'(m[i].tag) == t;
    tk = h && m[i].cnt >= 2;
    tg = h ? m[i].target : 64'd0;
  endfunction

  function automatic void model_upd(input bit e, uv, input logic [63:0] pc, input bit tk,
                                    input logic [63:0] tgt, input bit fl);
    int i = int'((pc / 4) % 32);
    int t = int'((pc / 128) % 256);
    int c = m[i].cnt;
    if (!e) return;
    if (fl) begin
      for (int k = 0; k < 32; k++) m[k].valid = 0;
    end else if (uv) begin
      if (m[i].valid && int'(m[i].tag) == t) begin
        c = tk ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
        m[i].cnt = 2'(c);
        if (tk) m[i].target = tgt;
      end else if (tk) begin
        m[i].valid = 1;
        m[i].tag = 8'(t);
        m[i].target = tgt;
        m[i].cnt = 2;
      end
    end
  endfunction

  task automatic step(input string name, input bit e, lv, input logic [63:0] lpc, input bit uv,
                      input logic [63:0] upc, input bit ut, input logic [63:0] utgt, input bit fl);
    bit h, tk;
    logic [63:0] tg;
    en = e; lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; flush = fl;
`ifdef BTB_FWD_EN
    model_upd(e, uv, upc, ut, utgt, fl);
    model_look(lpc, h, tk, tg);
`else
    model_look(lpc, h, tk, tg);
    model_upd(e, uv, upc, ut, utgt, fl);
`endif
    @(posedge clk); #1;
    chk({name, ".valid"}, pred_valid, e && lv);
    chk({name, ".hit"}, pred_hit, e && lv && h);
    chk({name, ".taken"}, pred_taken, e && lv && tk);
    chk({name, ".target"}, pred_target, (e && lv) ? tg : 64'd0);
  endtask

  task automatic look(input string name, input logic [63:0] pc);
    step(name, 1, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input string name, input logic [63:0] pc, input bit tk, input logic [63:0] tgt);
    step(name, 1, 0, 0, 1, pc, tk, tgt, 0);
  endtask

  function automatic logic [63:0] rnd_pc();
    logic [63:0] p = (64'($urandom_range(0, 3)) << 7) | (64'($urandom_range(0, 7)) << 2);
    p |= 64'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) p |= 64'h1_0000_0000;
    return p;
  endfunction

  initial begin
    bit exp_tk [7] = '{1, 1, 1, 1, 0, 0, 0};
    bit fl_hit;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", pred_valid, 0);
    chk("rst.hit", pred_hit, 0);
    chk("rst.taken", pred_taken, 0);
    chk("rst.target", pred_target, 0);
    arst = 0;

    look("cold", 64'h1000);
    chk("cold.hit_const", pred_hit, 0);
    upd("alloc", 64'h1000, 1, 64'h2000);
    look("alloc_look", 64'h1000);
    chk("alloc.target_const", pred_target, 64'h2000);
    chk("alloc.taken_const", pred_taken, 1);

    for (int k = 0; k < 7; k++) begin
      upd("sat_upd", 64'h1000, k < 3, 64'h2000);
      look("sat_look", 64'h1000);
      chk($sformatf("sat.taken%0d", k), pred_taken, exp_tk[k]);
    end

    upd("alloc2", 64'h1000, 1, 64'h2000);
    upd("alias", 64'h1080, 1, 64'h3000);
    look("alias_look", 64'h1000);
    chk("alias.hit_const", pred_hit, 0);
    look("alias_new", 64'h1080);
    chk("alias.new_target_const", pred_target, 64'h3000);

    upd("pre_flush", 64'h1000, 1, 64'h5000);
    step("flush", 1, 1, 64'h1000, 1, 64'h1000, 1, 64'h4444, 1);
`ifdef BTB_FWD_EN
    fl_hit = 0;
`else
    fl_hit = 1;
`endif
    chk("flush.hit_const", pred_hit, fl_hit);
    look("post_flush", 64'h1000);
    chk("post_flush.hit_const", pred_hit, 0);
    look("post_flush_alias", 64'h1080);

    upd("en_prep", 64'h2004, 1, 64'h6000);
    step("en_off", 0, 1, 64'h2004, 1, 64'h2004, 0, 0, 1);
    look("en_after", 64'h2004);
    chk("en_after.hit_const", pred_hit, 1);

    en = 1; lookup_valid = 1; lookup_pc = 64'h2004; upd_valid = 0; flush = 0;
    @(posedge clk); #1;
    chk("arst.pending_valid", pred_valid, 1);
    arst = 1;
    #1;
    chk("arst.async_valid", pred_valid, 0);
    chk("arst.async_hit", pred_hit, 0);
    model_reset();
    @(negedge clk);
    arst = 0;
    #1;
    chk("arst.release_valid", pred_valid, 0);
    look("arst_look", 64'h2004);
    chk("arst_look.hit_const", pred_hit, 0);
    look("arst_look2", 64'h1080);

    for (int k = 0; k < 1500; k++)
      step("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, rnd_pc(),
           $urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, $urandom_range(0, 29) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
